calc_sequencer: RTL and testbench

Control FSM for the calculator datapath. On `start_i` it reads a window of 64-bit SRAM words and adds the two 32-bit halves of each word. It packs two sums per result word into a LOWER/UPPER result buffer and writes each packed word back to SRAM at an incrementing write address. It sits between the host/config logic and the single-port SRAM, uses the package `state_t` and `buffer_loc_t` types, and owns all SRAM read/write strobes during a run.

---
 rtl/calc_sequencer.sv | 170 +++++++++++++++++
 tb/tb_calc_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Calculator sequencer: reads an SRAM window, adds the two lanes of each word,
// packs two sums per result word and writes them back. Optional build macro: CALC_SAT_EN.
package calc_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_RWAIT, S_ADD, S_WSET, S_WRITE, S_END
  } state_t;

  typedef enum logic {LOWER = 1'b0, UPPER = 1'b1} buffer_loc_t;
endpackage

module calc_sequencer
  import calc_sequencer_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int ADDR_W        = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        read_start_addr_i,
  input  logic [ADDR_W-1:0]        read_end_addr_i,
  input  logic [ADDR_W-1:0]        write_start_addr_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     overflow_o,
  output logic                     mem_re_o,
  output logic [ADDR_W-1:0]        mem_raddr_o,
  input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i,
  output logic                     mem_we_o,
  output logic [ADDR_W-1:0]        mem_waddr_o,
  output logic [MEM_WORD_SIZE-1:0] mem_wdata_o
);

  state_t                    state_q;
  buffer_loc_t               loc_q;
  logic [MEM_WORD_SIZE-1:0]  buf_q, buf_d, rdata_q;
  logic [ADDR_W-1:0]         rd_addr_q, rd_end_q, wr_addr_q;
  logic                      last_q;
  logic [DATA_W:0]           sum_full;
  logic [DATA_W-1:0]         sum_d;
  logic                      carry_d, at_last_d;

  logic                      busy_q, done_q, err_q, overflow_q, mem_re_q, mem_we_q;
  logic [ADDR_W-1:0]         mem_raddr_q, mem_waddr_q;
  logic [MEM_WORD_SIZE-1:0]  mem_wdata_q;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sum_full  = {1'b0, rdata_q[DATA_W-1:0]} + {1'b0, rdata_q[MEM_WORD_SIZE-1:DATA_W]};
    carry_d   = sum_full[DATA_W];
`ifdef CALC_SAT_EN
    sum_d     = carry_d ? {DATA_W{1'b1}} : sum_full[DATA_W-1:0];
`else
    sum_d     = sum_full[DATA_W-1:0];
`endif
    at_last_d = (rd_addr_q == rd_end_q);
    buf_d     = buf_q;
    // The buffer is cleared after every write, so a LOWER fill leaves the upper half zero.
    if (loc_q == LOWER) buf_d = {{(MEM_WORD_SIZE-DATA_W){1'b0}}, sum_d};
    else                buf_d = {sum_d, buf_q[DATA_W-1:0]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      loc_q       <= LOWER;
      buf_q       <= '0;
      rdata_q     <= '0;
      rd_addr_q   <= '0;
      rd_end_q    <= '0;
      wr_addr_q   <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      overflow_q  <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_raddr_q <= '0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rd_addr_q  <= read_start_addr_i;
            rd_end_q   <= read_end_addr_i;
            wr_addr_q  <= write_start_addr_i;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
            err_q      <= (read_end_addr_i < read_start_addr_i);
            if (read_end_addr_i < read_start_addr_i) begin
              done_q  <= 1'b1;
              state_q <= S_END;
            end else begin
              mem_re_q    <= 1'b1;
              mem_raddr_q <= read_start_addr_i;
              state_q     <= S_READ;
            end
          end
        end
        S_READ:  state_q <= S_RWAIT;
        S_RWAIT: begin
          rdata_q <= mem_rdata_i;
          state_q <= S_ADD;
        end
        S_ADD: begin
          buf_q      <= buf_d;
          loc_q      <= (loc_q == LOWER) ? UPPER : LOWER;
          overflow_q <= overflow_q | carry_d;
          rd_addr_q  <= rd_addr_q + ADDR_W'(1);
          last_q     <= at_last_d;
          if (loc_q == UPPER || at_last_d) begin
            mem_waddr_q <= wr_addr_q;
            mem_wdata_q <= buf_d;
            state_q     <= S_WSET;
          end else begin
            mem_re_q    <= 1'b1;
            mem_raddr_q <= rd_addr_q + ADDR_W'(1);
            state_q     <= S_READ;
          end
        end
        S_WSET: begin
          mem_we_q <= 1'b1;
          state_q  <= S_WRITE;
        end
        S_WRITE: begin
          wr_addr_q <= wr_addr_q + ADDR_W'(1);
          buf_q     <= '0;
          loc_q     <= LOWER;
          if (last_q) begin
            done_q  <= 1'b1;
            state_q <= S_END;
          end else begin
            mem_re_q    <= 1'b1;
            mem_raddr_q <= rd_addr_q;
            state_q     <= S_READ;
          end
        end
        S_END: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign overflow_o  = overflow_q;
  assign mem_re_o    = mem_re_q;
  assign mem_raddr_o = mem_raddr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_waddr_o = mem_waddr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: SRAM model plus a write scoreboard
// filled from an independent lane-sum model (honours CALC_SAT_EN).
module tb_calc_sequencer;
  localparam int DATA_W = 32;
  localparam int MEM_WORD_SIZE = 64;
  localparam int ADDR_W = 9;

  typedef struct {
    logic [ADDR_W-1:0]        addr;
    logic [MEM_WORD_SIZE-1:0] data;
  } wr_t;

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b1;
  logic                     start_i = 1'b0;
  logic [ADDR_W-1:0]        read_start_addr_i = '0;
  logic [ADDR_W-1:0]        read_end_addr_i = '0;
  logic [ADDR_W-1:0]        write_start_addr_i = '0;
  logic                     busy_o, done_o, err_o, overflow_o, mem_re_o, mem_we_o;
  logic [ADDR_W-1:0]        mem_raddr_o, mem_waddr_o;
  logic [MEM_WORD_SIZE-1:0] mem_rdata_i = '0;
  logic [MEM_WORD_SIZE-1:0] mem_wdata_o;

  logic [MEM_WORD_SIZE-1:0] mem [512];
  wr_t exp_q[$];
  wr_t mon_e;
  int checks = 0;
  int errors = 0;
  int writes = 0;
  int reads  = 0;

  always #5 clk_i = ~clk_i;

  calc_sequencer #(.DATA_W(DATA_W), .MEM_WORD_SIZE(MEM_WORD_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .read_start_addr_i(read_start_addr_i), .read_end_addr_i(read_end_addr_i),
    .write_start_addr_i(write_start_addr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .overflow_o(overflow_o),
    .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i),
    .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o)
  );

  // Single-port SRAM model with one-cycle read latency.
  always @(posedge clk_i) begin
    if (mem_we_o) mem[mem_waddr_o] <= mem_wdata_o;
    if (mem_re_o) mem_rdata_i <= mem[mem_raddr_o];
  end

  // Scoreboard: every write strobe pops one expected {addr, data}.
  always @(negedge clk_i) begin
    if (mem_re_o) reads++;
    if (mem_we_o) begin
      writes++;
      checks++;
      if (mem_re_o) begin
        errors++;
        $display("FAIL strobe_overlap: re=%b we=%b, required re and we never both high", mem_re_o, mem_we_o);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%h, required no write", mem_waddr_o, mem_wdata_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_waddr_o, mem_wdata_o} !== {mon_e.addr, mon_e.data}) begin
          errors++;
          $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                   mem_waddr_o, mem_wdata_o, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  function automatic logic [DATA_W:0] model_sum(input logic [MEM_WORD_SIZE-1:0] w);
    logic [DATA_W:0] s;
    s = {1'b0, w[31:0]} + {1'b0, w[63:32]};
`ifdef CALC_SAT_EN
    if (s[DATA_W]) s[DATA_W-1:0] = '1;
`endif
    return s;
  endfunction

  // Pushes the expected writes of a run, computed from the current memory image.
  task automatic push_expected(input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] re,
                               input logic [ADDR_W-1:0] ws, output logic ovf);
    logic [DATA_W:0]   lo, hi;
    logic [ADDR_W-1:0] wa;
    wr_t               e;
    wa  = ws;
    ovf = 1'b0;
    for (int a = int'(rs); a <= int'(re); a += 2) begin
      lo  = model_sum(mem[ADDR_W'(a)]);
      hi  = (a + 1 <= int'(re)) ? model_sum(mem[ADDR_W'(a + 1)]) : '0;
      ovf = ovf | lo[DATA_W] | hi[DATA_W];
      e.addr = wa;
      e.data = {hi[DATA_W-1:0], lo[DATA_W-1:0]};
      exp_q.push_back(e);
      wa = wa + ADDR_W'(1);
    end
  endtask

  // Starts a run and waits (bounded) for done_o; cyc is the cycle done_o is seen
  // with the start cycle as 0. poke>0 re-asserts start_i mid-run in that cycle.
  task automatic run(input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] re,
                     input logic [ADDR_W-1:0] ws, input int poke, output int cyc);
    @(negedge clk_i);
    read_start_addr_i  = rs;
    read_end_addr_i    = re;
    write_start_addr_i = ws;
    start_i            = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc     = 1;
    while (done_o !== 1'b1 && cyc < 200) begin
      if (cyc == poke) begin
        start_i            = 1'b1;
        read_start_addr_i  = 9'd5;
        read_end_addr_i    = 9'd1;
        write_start_addr_i = 9'd300;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      cyc++;
    end
    start_i = 1'b0;
    if (done_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: done_o=%b after %0d cycles, required 1", done_o, cyc);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    checks++;
    if ({busy_o, done_o, err_o, overflow_o, mem_re_o, mem_raddr_o, mem_we_o,
         mem_waddr_o, mem_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b ovf=%b re=%b raddr=%0d we=%b waddr=%0d wdata=%h, required all 0",
               busy_o, done_o, err_o, overflow_o, mem_re_o, mem_raddr_o, mem_we_o, mem_waddr_o, mem_wdata_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_basic_pair();
    int cyc, w0;
    logic ovf;
    mem[0] = {32'd2, 32'd3};
    mem[1] = {32'd10, 32'd20};
    push_expected(9'd0, 9'd1, 9'd8, ovf);
    w0 = writes;
    run(9'd0, 9'd1, 9'd8, 0, cyc);
    checks++;
    if (cyc !== 9) begin errors++; $display("FAIL basic_done_cycle: got %0d, required 9", cyc); end
    checks++;
    if ({overflow_o, err_o, busy_o} !== 3'b001) begin
      errors++; $display("FAIL basic_flags: ovf,err,busy=%b%b%b, required 001", overflow_o, err_o, busy_o);
    end
    @(negedge clk_i);
    checks++;
    if ({done_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL basic_idle_after: done,busy=%b%b, required 00", done_o, busy_o);
    end
    checks++;
    if (writes - w0 !== 1) begin errors++; $display("FAIL basic_write_count: got %0d, required 1", writes - w0); end
    checks++;
    if (mem[8] !== {32'd30, 32'd5}) begin
      errors++; $display("FAIL basic_mem8: got %h, required %h", mem[8], {32'd30, 32'd5});
    end
  endtask

  task automatic test_odd_flush();
    int cyc, w0;
    logic ovf;
    mem[4] = {32'd0, 32'd1};
    mem[5] = {32'd1, 32'd1};
    mem[6] = {32'd1, 32'd2};
    push_expected(9'd4, 9'd6, 9'd100, ovf);
    w0 = writes;
    run(9'd4, 9'd6, 9'd100, 0, cyc);
    checks++;
    if (cyc !== 14) begin errors++; $display("FAIL odd_done_cycle: got %0d, required 14", cyc); end
    @(negedge clk_i);
    checks++;
    if (writes - w0 !== 2) begin errors++; $display("FAIL odd_write_count: got %0d, required 2", writes - w0); end
    checks++;
    if ({mem[101], mem[100]} !== {32'd0, 32'd3, 32'd2, 32'd1}) begin
      errors++; $display("FAIL odd_mem: got mem[101]=%h mem[100]=%h, required %h %h",
                         mem[101], mem[100], {32'd0, 32'd3}, {32'd2, 32'd1});
    end
  endtask

  task automatic test_overflow();
    int cyc;
    logic ovf;
    logic [DATA_W-1:0] exp_lo;
`ifdef CALC_SAT_EN
    exp_lo = 32'hFFFF_FFFF;
`else
    exp_lo = 32'h1;
`endif
    mem[20] = {32'hFFFF_FFFF, 32'h2};
    mem[21] = {32'd0, 32'd7};
    push_expected(9'd20, 9'd21, 9'd30, ovf);
    run(9'd20, 9'd21, 9'd30, 0, cyc);
    checks++;
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b, required 1", overflow_o); end
    repeat (5) @(negedge clk_i);
    checks++;
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b, required 1", overflow_o); end
    checks++;
    if (mem[30] !== {32'd7, exp_lo}) begin
      errors++; $display("FAIL overflow_mem30: got %h, required %h", mem[30], {32'd7, exp_lo});
    end
  endtask

  task automatic test_range_error();
    int cyc, w0, r0;
    w0 = writes;
    r0 = reads;
    run(9'd10, 9'd9, 9'd50, 0, cyc);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL err_done_cycle: got %0d, required 1", cyc); end
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL err_flag: got %b, required 1", err_o); end
    @(negedge clk_i);
    checks++;
    if ((writes - w0) + (reads - r0) !== 0) begin
      errors++; $display("FAIL err_no_access: reads=%0d writes=%0d, required 0 0", reads - r0, writes - w0);
    end
  endtask

  // Also re-asserts start_i mid-run, which must be ignored.
  task automatic test_write_wrap();
    int cyc, w0;
    logic ovf;
    mem[0] = {32'd1, 32'd2};
    mem[1] = {32'd3, 32'd4};
    mem[2] = {32'd5, 32'd6};
    mem[3] = {32'd7, 32'd8};
    push_expected(9'd0, 9'd3, 9'd511, ovf);
    w0 = writes;
    run(9'd0, 9'd3, 9'd511, 3, cyc);
    checks++;
    if (cyc !== 17) begin errors++; $display("FAIL wrap_done_cycle: got %0d, required 17", cyc); end
    checks++;
    if ({overflow_o, err_o} !== 2'b00) begin
      errors++; $display("FAIL wrap_flags_cleared: ovf,err=%b%b, required 00", overflow_o, err_o);
    end
    @(negedge clk_i);
    checks++;
    if (writes - w0 !== 2) begin errors++; $display("FAIL wrap_write_count: got %0d, required 2", writes - w0); end
    checks++;
    if ({mem[511], mem[0]} !== {32'd7, 32'd3, 32'd15, 32'd11}) begin
      errors++; $display("FAIL wrap_mem: got mem[511]=%h mem[0]=%h, required %h %h",
                         mem[511], mem[0], {32'd7, 32'd3}, {32'd15, 32'd11});
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, w0;
    logic ovf;
    mem[0]  = {32'd2, 32'd3};
    mem[1]  = {32'd10, 32'd20};
    mem[40] = '0;
    w0 = writes;
    @(negedge clk_i);
    read_start_addr_i  = 9'd0;
    read_end_addr_i    = 9'd1;
    write_start_addr_i = 9'd40;
    start_i            = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (6) @(negedge clk_i);
    checks++;
    if ({mem_we_o, mem_waddr_o, mem_wdata_o} !== {1'b0, 9'd40, 32'd30, 32'd5}) begin
      errors++; $display("FAIL wset_drive: we=%b waddr=%0d wdata=%h, required 0 40 %h",
                         mem_we_o, mem_waddr_o, mem_wdata_o, {32'd30, 32'd5});
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checks++;
    if ({busy_o, done_o, err_o, overflow_o, mem_re_o, mem_raddr_o, mem_we_o,
         mem_waddr_o, mem_wdata_o} !== '0) begin
      errors++; $display("FAIL midrun_reset_outputs: busy=%b re=%b we=%b waddr=%0d wdata=%h, required all 0",
                         busy_o, mem_re_o, mem_we_o, mem_waddr_o, mem_wdata_o);
    end
    repeat (4) @(negedge clk_i);
    checks++;
    if (writes - w0 !== 0) begin errors++; $display("FAIL midrun_no_write: got %0d writes, required 0", writes - w0); end
    push_expected(9'd0, 9'd1, 9'd40, ovf);
    run(9'd0, 9'd1, 9'd40, 0, cyc);
    checks++;
    if (cyc !== 9) begin errors++; $display("FAIL rerun_done_cycle: got %0d, required 9", cyc); end
    @(negedge clk_i);
    checks++;
    if (mem[40] !== {32'd30, 32'd5}) begin
      errors++; $display("FAIL rerun_mem40: got %h, required %h", mem[40], {32'd30, 32'd5});
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    test_reset();
    test_basic_pair();
    test_odd_flush();
    test_overflow();
    test_range_error();
    test_write_wrap();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
